// File: rtl/sys_pkg.sv
// sys_pkg: shared fixed-point output type and stream-convert defaults
package sys_pkg;
  localparam int FPT_W = 32;
  localparam int FRAC_BITS_DEF = 16;
  localparam int FRAME_LEN_DEF = 8;
  typedef logic signed [FPT_W-1:0] fpt_t;
endpackage

// File: rtl/ip_stream_convert_if.sv
// ip_stream_convert_if: raw-sample input and fixed-point output stream handshakes
interface ip_stream_convert_if
  import sys_pkg::*;
#(
  parameter int RAW_W = 32,
  parameter int OUT_W = $bits(fpt_t)
);
  logic in_valid, in_ready, out_valid, out_ready, out_last;
  logic [RAW_W-1:0] in_data;
  logic [OUT_W-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/conv_fifo.sv
// conv_fifo: first-word fall-through FIFO with count-based full/empty and sync clear
module conv_fifo #(
  parameter int W = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  // Output forced to zero when empty so nothing stale shows during reset.
  assign dout = empty ? '0 : mem_q[rd_q];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/ip_stream_convert.sv
// ip_stream_convert: raw integer to fixed-point stream with FFT framing; IP_CONVERT_SAT_EN enables saturation
module ip_stream_convert
  import sys_pkg::*;
#(
  parameter int RAW_W = 32,
  parameter int OUT_W = FPT_W,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int DEPTH = 4
) (
  ip_stream_convert_if.slave s,
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic ovf_clr,
  output logic ovf
);
  localparam int CW = (RAW_W + FRAC_BITS > OUT_W) ? RAW_W + FRAC_BITS : OUT_W;
  localparam int FW = $clog2(FRAME_LEN);
  logic signed [CW-1:0] ext;
  logic [OUT_W-1:0] res;
  logic [OUT_W:0] dout;
  logic [FW-1:0] idx_q, idx_d;
  logic rdy_q, acc, full, empty;
  assign ext = CW'(signed'(s.in_data)) <<< FRAC_BITS;
  // rdy_q keeps in_ready low until the first edge after reset release.
  assign s.in_ready = rdy_q & ~full & ~flush;
  assign s.out_valid = ~empty;
  assign {s.out_last, s.out_data} = dout;
  assign acc = s.in_valid & s.in_ready;
  assign idx_d = flush ? '0 : idx_q + FW'(acc);
`ifdef IP_CONVERT_SAT_EN
  logic fits, ovf_q, ovf_d;
  assign fits = ext == CW'(signed'(ext[OUT_W-1:0]));
  assign res = fits ? ext[OUT_W-1:0] : {ext[CW-1], {(OUT_W-1){~ext[CW-1]}}};
  assign ovf_d = (acc & ~fits) | (ovf_q & ~ovf_clr);
  assign ovf = ovf_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
`else
  logic unused_ok;
  assign res = ext[OUT_W-1:0];
  assign ovf = 1'b0;
  assign unused_ok = ^{ovf_clr, ext};
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy_q <= 1'b0;
      idx_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      idx_q <= idx_d;
    end
  conv_fifo #(.W(OUT_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clr(flush),
    .push(acc),
    .pop(s.out_ready),
    .din({&idx_q, res}),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_ip_stream_convert.sv
// tb_ip_stream_convert: randomized scoreboard bench for ip_stream_convert
module tb_ip_stream_convert;
  logic clk = 0, rst_n = 1, flush = 0, ovf_clr = 0;
  logic ovf;
  int nvec = 0, nerr = 0, idx_m = 0, n_out = 0;
  logic ovf_m = 0;
  logic [31:0] last_hist = 0;
  logic [32:0] exp_q[$];
`ifdef IP_CONVERT_SAT_EN
  localparam bit SAT = 1;
`else
  localparam bit SAT = 0;
`endif
  ip_stream_convert_if #(.RAW_W(32), .OUT_W(32)) ifc ();
  ip_stream_convert dut (.s(ifc), .clk(clk), .rst_n(rst_n), .flush(flush), .ovf_clr(ovf_clr), .ovf(ovf));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {overflow, value}: raw * 2^16 as a real integer, then clamp or keep the low 32 bits
  function automatic logic [32:0] model(input logic [31:0] d);
    longint v = longint'($signed(d)) * 65536;
    if (SAT && v > 64'sh7fffffff) return {1'b1, 32'h7fffffff};
    if (SAT && v < -64'sh80000000) return {1'b1, 32'h80000000};
    return {1'b0, v[31:0]};
  endfunction

  always @(negedge clk) begin
    logic [32:0] e, r;
    logic of;
    if (rst_n) begin
      of = 0;
      chk("ovf", {63'd0, ovf}, {63'd0, ovf_m});
      if (ifc.out_valid && ifc.out_ready) begin
        n_out++;
        last_hist = {last_hist[30:0], ifc.out_last};
        if (exp_q.size() == 0) chk("spurious_out", {63'd0, ifc.out_valid}, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", {32'd0, ifc.out_data}, {32'd0, e[31:0]});
          chk("out_last", {63'd0, ifc.out_last}, {63'd0, e[32]});
        end
      end
      if (flush) begin
        chk("in_ready_flush", {63'd0, ifc.in_ready}, 64'd0);
        exp_q.delete();
        idx_m = 0;
      end else if (ifc.in_valid && ifc.in_ready) begin
        r = model(ifc.in_data);
        exp_q.push_back({idx_m == 7, r[31:0]});
        idx_m = (idx_m + 1) % 8;
        of = r[32];
      end
      ovf_m = of | (ovf_m & ~ovf_clr);
    end
  end

  task automatic do_reset();
    rst_n = 0;
    exp_q.delete();
    idx_m = 0;
    ovf_m = 0;
    #1;
    chk("rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, ifc.in_ready}, 64'd0);
    chk("rst_out_data", {32'd0, ifc.out_data}, 64'd0);
    chk("rst_out_last", {63'd0, ifc.out_last}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1 chk("in_ready_after_rst", {63'd0, ifc.in_ready}, 64'd1);
  endtask

  task automatic send(input logic [31:0] d, input bit hold = 0);
    int n = 0;
    ifc.in_valid = 1;
    ifc.in_data = d;
    @(negedge clk);
    while (!ifc.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    if (!hold) ifc.in_valid = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    ifc.in_valid = 0;
    ifc.in_data = 0;
    ifc.out_ready = 1;
    #1 do_reset();
    send(32'd3);
    chk("lat_valid", {63'd0, ifc.out_valid}, 64'd1);
    chk("lat_data_pos", {32'd0, ifc.out_data}, 64'h0003_0000);
    send(32'hffff_ffff);
    chk("lat_data_neg", {32'd0, ifc.out_data}, 64'hffff_0000);
    send(32'h0000_8000);
    chk("conv_8000", {32'd0, ifc.out_data}, SAT ? 64'h7fff_ffff : 64'h8000_0000);
    chk("ovf_8000", {63'd0, ovf}, {63'd0, SAT});
    send(32'hffff_7fff);
    chk("conv_ffff7fff", {32'd0, ifc.out_data}, SAT ? 64'h8000_0000 : 64'h7fff_0000);
    ovf_clr = 1;
    wait_cycles(1);
    ovf_clr = 0;
    chk("ovf_cleared", {63'd0, ovf}, 64'd0);
    wait_cycles(3);
    ifc.out_ready = 0;
    ifc.in_valid = 1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      ifc.in_data = 100 + n;
      @(negedge clk);
      if (ifc.in_ready) n++;
      @(posedge clk);
      #1;
    end
    chk("bp_accepted", 64'(n), 64'd4);
    chk("bp_in_ready", {63'd0, ifc.in_ready}, 64'd0);
    chk("bp_hold", {32'd0, ifc.out_data}, 64'h0064_0000);
    ifc.in_valid = 0;
    ifc.out_ready = 1;
    wait_cycles(6);
    chk("bp_drained", {63'd0, ifc.out_valid}, 64'd0);
    chk("bp_scoreboard", 64'(exp_q.size()), 64'd0);
    n_out = 0;
    last_hist = 0;
    for (int i = 0; i < 16; i++) send(32'(i + 1), 1);
    ifc.in_valid = 0;
    wait_cycles(3);
    chk("frame16_lasts", {48'd0, last_hist[15:0]}, 64'h0101);
    chk("frame16_count", 64'(n_out), 64'd16);
    ifc.out_ready = 0;
    for (int i = 0; i < 3; i++) send(32'(200 + i));
    flush = 1;
    ifc.in_valid = 1;
    ifc.in_data = 999;
    wait_cycles(1);
    flush = 0;
    ifc.in_valid = 0;
    chk("flush_empty", {63'd0, ifc.out_valid}, 64'd0);
    ifc.out_ready = 1;
    n_out = 0;
    last_hist = 0;
    for (int i = 0; i < 8; i++) send(32'(300 + i));
    wait_cycles(3);
    chk("flush_frame_lasts", {56'd0, last_hist[7:0]}, 64'h01);
    chk("flush_frame_count", 64'(n_out), 64'd8);
    ifc.out_ready = 0;
    for (int i = 0; i < 2; i++) send(32'(400 + i));
    chk("pre_rst_valid", {63'd0, ifc.out_valid}, 64'd1);
    do_reset();
    ifc.out_ready = 1;
    n_out = 0;
    last_hist = 0;
    for (int i = 0; i < 8; i++) send(32'(500 + i));
    wait_cycles(3);
    chk("rst_frame_lasts", {56'd0, last_hist[7:0]}, 64'h01);
    chk("rst_frame_count", 64'(n_out), 64'd8);
    for (int i = 0; i < 400; i++) begin
      ifc.in_valid = 1'($urandom % 2);
      ifc.in_data = ($urandom % 4 == 0) ? $urandom : 32'(int'($urandom_range(0, 65535)) - 32768);
      ifc.out_ready = ($urandom % 4) != 0;
      flush = ($urandom % 40) == 0;
      ovf_clr = ($urandom % 8) == 0;
      wait_cycles(1);
    end
    ifc.in_valid = 0;
    flush = 0;
    ovf_clr = 0;
    ifc.out_ready = 1;
    wait_cycles(8);
    chk("final_scoreboard", 64'(exp_q.size()), 64'd0);
    chk("final_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
